// File: rtl/baud_switch_ctrl.sv
// Sequences a run-time change of the 16x baud-tick generator rate: drain the UART,
// apply the new selection, pulse the generator reset and confirm a tick appears.
module baud_switch_ctrl #(
  parameter logic [1:0]  DEF_SEL    = 2'b10,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 2048,
  parameter int unsigned TW         = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [1:0] cfg_sel,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       busy,
  input  logic       rx_idle,
  input  logic       tx_idle,
  input  logic       gen_tick,
  output logic [1:0] baud_sel,
  output logic       gen_rst,
  output logic       uart_hold
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    GRST,
    VERIFY,
    DONE
  } state_t;

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [1:0]    pend_sel, pend_sel_nx;
  logic [1:0]    baud_sel_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          err_nx;

  always_comb begin
    state_nx    = state;
    pend_sel_nx = pend_sel;
    baud_sel_nx = baud_sel;
    timer_nx    = timer;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req) begin
          pend_sel_nx = cfg_sel;
          state_nx    = (cfg_sel == baud_sel) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (rx_idle && tx_idle) begin
          baud_sel_nx = pend_sel;
          timer_nx    = '0;
          state_nx    = GRST;
        end
      end
      GRST: begin
        if (timer == RST_LAST) begin
          timer_nx = '0;
          state_nx = VERIFY;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      VERIFY: begin
        // A tick on the final timeout cycle still counts as success.
        if (gen_tick) begin
          state_nx = DONE;
        end else if (timer == TO_LAST) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_sel  <= DEF_SEL;
      baud_sel  <= DEF_SEL;
      timer     <= '0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      gen_rst   <= 1'b0;
      uart_hold <= 1'b0;
    end else begin
      state     <= state_nx;
      pend_sel  <= pend_sel_nx;
      baud_sel  <= baud_sel_nx;
      timer     <= timer_nx;
      cfg_ack   <= (state_nx == DONE);
      cfg_err   <= err_nx;
      busy      <= (state_nx != IDLE);
      gen_rst   <= (state_nx == GRST);
      uart_hold <= (state_nx == DRAIN) || (state_nx == GRST) || (state_nx == VERIFY);
    end
  end

endmodule

// File: tb/tb_baud_switch_ctrl.sv
// Scoreboard bench for baud_switch_ctrl: stimulus pushes expected acks, a monitor
// pops and checks error flag, selection and tick-to-ack latency.
`timescale 1ns/1ps
module tb_baud_switch_ctrl;

  localparam logic [1:0] DEF_SEL    = 2'b10;
  localparam int         RST_CYCLES = 4;
  localparam int         TIMEOUT    = 2048;
  localparam int         NO_TICK    = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic       cfg_ack, cfg_err, busy;
  logic       rx_idle = 1'b1;
  logic       tx_idle = 1'b1;
  logic       gen_tick = 1'b0;
  logic [1:0] baud_sel;
  logic       gen_rst, uart_hold;

  baud_switch_ctrl #(
    .DEF_SEL   (DEF_SEL),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT),
    .TW        (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_req  (cfg_req),
    .cfg_sel  (cfg_sel),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .rx_idle  (rx_idle),
    .tx_idle  (tx_idle),
    .gen_tick (gen_tick),
    .baud_sel (baud_sel),
    .gen_rst  (gen_rst),
    .uart_hold(uart_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [1:0] sel;
    logic       same;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] model_sel = DEF_SEL;
  int         tick_delay = NO_TICK;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: a switch to the current rate is a no-op; otherwise the new rate is
  // applied and the ack lands one cycle after the tick, or TIMEOUT cycles without one.
  function automatic void expect_txn(logic [1:0] sel, int d);
    exp_t e;
    e.sel = sel;
    if (sel == model_sel) begin
      e.same = 1'b1; e.err = 1'b0; e.lat = 0;
    end else begin
      e.same = 1'b0;
      model_sel = sel;
      if (d < 0 || d >= TIMEOUT) begin
        e.err = 1'b1; e.lat = TIMEOUT;
      end else begin
        e.err = 1'b0; e.lat = d + 1;
      end
    end
    sb.push_back(e);
  endfunction

  // Generator model: one tick tick_delay cycles after gen_rst falls.
  initial begin
    int  d;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else if (!gen_rst && prev && tick_delay >= 0) begin
        d = tick_delay;
        if (d == 0) gen_tick = 1'b1;
        else begin
          repeat (d) @(posedge clk);
          #1 gen_tick = 1'b1;
        end
        @(posedge clk);
        #1 gen_tick = 1'b0;
        prev = 1'b0;
      end else prev = gen_rst;
    end
  end

  // Stray tick while the generator is held in reset; must be ignored.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && gen_rst && !prev && ($urandom % 2 == 0)) begin
        @(posedge clk);
        #1 gen_tick = 1'b1;
        @(posedge clk);
        #1 gen_tick = 1'b0;
      end
      prev = gen_rst;
    end
  end

  // Monitor
  initial begin
    int   cyc, fall_cyc, hi_cnt;
    logic prev_gr, rst_seen;
    exp_t e;
    cyc = 0; fall_cyc = 0; hi_cnt = 0; prev_gr = 1'b0; rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_gr = 1'b0; hi_cnt = 0; rst_seen = 1'b0;
      end else begin
        if (gen_rst) begin
          if (!prev_gr) rst_seen = 1'b1;
          hi_cnt++;
          chk("hold_during_gen_rst", uart_hold, 1);
        end else if (prev_gr) begin
          chk("gen_rst_width", hi_cnt, RST_CYCLES);
          hi_cnt = 0;
          fall_cyc = cyc;
        end
        prev_gr = gen_rst;
        if (cfg_err) chk("err_needs_ack", cfg_ack, 1);
        if (cfg_ack) begin
          chk("ack_expected", int'(sb.size() > 0), 1);
          chk("hold_low_at_ack", uart_hold, 0);
          chk("busy_at_ack", busy, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("err", cfg_err, e.err);
            chk("baud_sel_at_ack", baud_sel, e.sel);
            if (e.same) chk("no_gen_rst_same_sel", rst_seen, 0);
            else        chk("ack_latency", cyc - fall_cyc, e.lat);
          end
          rst_seen = 1'b0;
        end
      end
    end
  end

  task automatic start_req(input logic [1:0] sel, input int d);
    @(posedge clk);
    #1;
    chk("idle_before_req", busy, 0);
    tick_delay = d;
    expect_txn(sel, d);
    cfg_sel = sel;
    cfg_req = 1'b1;
  endtask

  task automatic wait_ack(input int budget, input bit drop);
    int n;
    n = 0;
    while (!cfg_ack && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_within_budget", cfg_ack, 1);
    if (drop) cfg_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int         bad, n, gap, r, d;
    logic [1:0] sel;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_baud_sel", baud_sel, DEF_SEL);
    chk("rst_busy", busy, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_gen_rst", gen_rst, 0);
    chk("rst_hold", uart_hold, 0);
    rst = 1'b0;

    // Same selection: ack next cycle, no drain or reset.
    start_req(2'b10, 0);
    @(posedge clk);
    #1;
    chk("same_sel_ack_next", cfg_ack, 1);
    chk("same_sel_hold", uart_hold, 0);
    wait_ack(10, 1'b1);

    // Idle UART, switch to 19200.
    start_req(2'b11, 160);
    @(posedge clk);
    #1;
    chk("drain_hold", uart_hold, 1);
    chk("drain_gen_rst", gen_rst, 0);
    @(posedge clk);
    #1;
    chk("grst_at_2", gen_rst, 1);
    chk("grst_sel", baud_sel, 3);
    wait_ack(4000, 1'b1);

    // TX busy holds the controller in drain.
    tx_idle = 1'b0;
    start_req(2'b00, 50);
    bad = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (gen_rst || baud_sel != 2'b11) bad++;
    end
    chk("drain_waits", bad, 0);
    chk("drain_busy", busy, 1);
    chk("drain_hold_long", uart_hold, 1);
    tx_idle = 1'b1;
    @(posedge clk);
    #1;
    chk("grst_after_drain", gen_rst, 1);
    chk("sel_after_drain", baud_sel, 0);
    wait_ack(4000, 1'b1);

    // Timeout, tick on the last cycle, tick on the first cycle.
    start_req(2'b01, NO_TICK);
    wait_ack(4000, 1'b1);
    chk("sel_kept_on_err", baud_sel, 1);
    start_req(2'b10, TIMEOUT - 1);
    wait_ack(4000, 1'b1);
    start_req(2'b11, 0);
    wait_ack(4000, 1'b1);

    // Reset while the generator reset is asserted.
    start_req(2'b01, 100);
    n = 0;
    while (!gen_rst && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_grst", gen_rst, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_gen_rst", gen_rst, 0);
    chk("midrst_hold", uart_hold, 0);
    chk("midrst_sel", baud_sel, DEF_SEL);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", cfg_ack, 0);
    sb.delete();
    model_sel = DEF_SEL;
    rst = 1'b0;
    cfg_req = 1'b0;
    repeat (150) @(posedge clk);

    // Request held through ack starts a second transaction; pulses while busy ignored.
    start_req(2'b00, 30);
    wait_ack(4000, 1'b0);
    cfg_sel = 2'b01;
    tick_delay = 30;
    expect_txn(2'b01, 30);
    @(posedge clk);
    #1;
    chk("held_idle_cycle", busy, 0);
    @(posedge clk);
    #1;
    chk("held_restart_busy", busy, 1);
    chk("held_restart_hold", uart_hold, 1);
    cfg_req = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      cfg_req = 1'($urandom);
      cfg_sel = 2'($urandom);
    end
    cfg_req = 1'b0;
    wait_ack(4000, 1'b1);

    // Random transactions.
    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom_range(0, 3));
      r   = int'($urandom_range(0, 7));
      d   = (r == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 300));
      gap = (sel != model_sel) ? int'($urandom_range(0, 15)) : 0;
      if (gap > 0) rx_idle = 1'b0;
      start_req(sel, d);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1 rx_idle = 1'b1;
      end
      wait_ack(4000, 1'b1);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
